// File: rtl/vending_controller_param.sv
// Parametrised vending controller: N priced products, saturating credit, cancel/refund, timed dispense.
// Optional per-product stock tracking is compiled in when VEND_STOCK_EN is defined.
`timescale 1ns/1ps
module vending_controller_param #(
    parameter int NUM_PRODUCTS = 3,
    parameter int CREDIT_W     = 8,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_LIST = {8'd20, 8'd15, 8'd10},
    parameter int MAX_CREDIT   = 50,
    parameter int DISP_CYCLES  = 4,
    parameter int STOCK_INIT   = 5,
    localparam int ID_W        = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    coin_5,
    input  logic                    coin_10,
    input  logic [NUM_PRODUCTS-1:0] select,
    input  logic                    cancel,
    output logic                    dispense,
    output logic [ID_W-1:0]         dispense_id,
    output logic                    change,
    output logic [CREDIT_W-1:0]     change_amt,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    coin_reject,
    output logic                    busy,
    output logic [NUM_PRODUCTS-1:0] sold_out
);
    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE} state_t;

    localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [CREDIT_W:0] L_MAX = (CREDIT_W+1)'(MAX_CREDIT);

    state_t                  r_state, w_state_nxt;
    logic                    r_c5_s, r_c5_p, r_c10_s, r_c10_p, r_can_s, r_can_p;
    logic [NUM_PRODUCTS-1:0] r_sel_s, r_sel_p;
    logic [CREDIT_W-1:0]     r_credit, w_credit_nxt, r_amt, w_amt_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [ID_W-1:0]         r_id, w_id_nxt, w_win_idx;
    logic                    r_disp, w_disp_nxt, r_chg, w_chg_nxt, r_rej, w_rej_nxt, r_busy;
    logic                    w_e5, w_e10, w_ecan, w_win_vld, w_coin_ok, w_buy, w_vend;
    logic [NUM_PRODUCTS-1:0] w_esel, w_sold;
    logic [CREDIT_W:0]       w_coin_val, w_coin_sum, w_base;
    logic [CREDIT_W-1:0]     w_price;

    // Inputs are registered, then edge-detected against the previous sample; both reset
    // high so a switch held through reset needs a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c5_s  <= 1'b1; r_c5_p  <= 1'b1;
            r_c10_s <= 1'b1; r_c10_p <= 1'b1;
            r_can_s <= 1'b1; r_can_p <= 1'b1;
            r_sel_s <= '1;   r_sel_p <= '1;
        end else begin
            r_c5_s  <= coin_5;  r_c5_p  <= r_c5_s;
            r_c10_s <= coin_10; r_c10_p <= r_c10_s;
            r_can_s <= cancel;  r_can_p <= r_can_s;
            r_sel_s <= select;  r_sel_p <= r_sel_s;
        end
    end

    assign w_e5       = r_c5_s & ~r_c5_p;
    assign w_e10      = r_c10_s & ~r_c10_p;
    assign w_ecan     = r_can_s & ~r_can_p;
    assign w_esel     = r_sel_s & ~r_sel_p;
    assign w_coin_val = (w_e5 ? (CREDIT_W+1)'(5) : '0) + (w_e10 ? (CREDIT_W+1)'(10) : '0);
    assign w_coin_sum = {1'b0, r_credit} + w_coin_val;
    assign w_coin_ok  = (w_coin_sum <= L_MAX);

    // Lowest-index select edge wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int i = NUM_PRODUCTS-1; i >= 0; i--) begin
            if (w_esel[i]) begin
                w_win_vld = 1'b1;
                w_win_idx = ID_W'(i);
            end
        end
    end

    assign w_price = PRICE_LIST[int'(w_win_idx)*CREDIT_W +: CREDIT_W];
    assign w_buy   = w_win_vld && !w_sold[w_win_idx] && (r_credit >= w_price);

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_disp_nxt   = r_disp;
        w_cnt_nxt    = r_cnt;
        w_id_nxt     = r_id;
        w_chg_nxt    = 1'b0;
        w_amt_nxt    = '0;
        w_rej_nxt    = 1'b0;
        w_vend       = 1'b0;
        w_base       = {1'b0, r_credit} + (w_coin_ok ? w_coin_val : '0);
        case (r_state)
            S_IDLE, S_CREDIT: begin
                w_rej_nxt = (w_coin_val != '0) && !w_coin_ok;
                if (w_ecan && r_state == S_CREDIT) begin
                    w_state_nxt  = S_CHANGE;
                    w_chg_nxt    = 1'b1;
                    w_amt_nxt    = CREDIT_W'(w_base);
                    w_credit_nxt = '0;
                end else if (!w_ecan && w_buy) begin
                    w_state_nxt  = S_DISPENSE;
                    w_credit_nxt = CREDIT_W'(w_base - {1'b0, w_price});
                    w_disp_nxt   = 1'b1;
                    w_cnt_nxt    = CNT_W'(DISP_CYCLES - 1);
                    w_id_nxt     = w_win_idx;
                    w_vend       = 1'b1;
                end else begin
                    w_credit_nxt = CREDIT_W'(w_base);
                    w_state_nxt  = (w_base != '0) ? S_CREDIT : S_IDLE;
                end
            end
            S_DISPENSE: begin
                w_rej_nxt = (w_coin_val != '0);
                if (r_cnt == '0) begin
                    w_disp_nxt = 1'b0;
                    if (r_credit != '0) begin
                        w_state_nxt  = S_CHANGE;
                        w_chg_nxt    = 1'b1;
                        w_amt_nxt    = r_credit;
                        w_credit_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_CHANGE: begin
                w_rej_nxt   = (w_coin_val != '0);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_disp   <= 1'b0;
            r_cnt    <= '0;
            r_id     <= '0;
            r_chg    <= 1'b0;
            r_amt    <= '0;
            r_rej    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_disp   <= w_disp_nxt;
            r_cnt    <= w_cnt_nxt;
            r_id     <= w_id_nxt;
            r_chg    <= w_chg_nxt;
            r_amt    <= w_amt_nxt;
            r_rej    <= w_rej_nxt;
            r_busy   <= (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE);
        end
    end

`ifdef VEND_STOCK_EN
    localparam int STK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
    logic [NUM_PRODUCTS-1:0][STK_W-1:0] r_stock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= STK_W'(STOCK_INIT);
        end else if (w_vend) begin
            r_stock[w_win_idx] <= r_stock[w_win_idx] - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PRODUCTS; i++) w_sold[i] = (r_stock[i] == '0);
    end
`else
    assign w_sold = '0;
`endif

    assign dispense    = r_disp;
    assign dispense_id = r_id;
    assign change      = r_chg;
    assign change_amt  = r_amt;
    assign credit      = r_credit;
    assign coin_reject = r_rej;
    assign busy        = r_busy;
    assign sold_out    = w_sold;
endmodule

// File: tb/tb_vending_controller_param.sv
// Bench for vending_controller_param: vector tables scored through a two-deep expected-result queue,
// plus hand sequences for reset behaviour and stock depletion (VEND_STOCK_EN builds).
`timescale 1ns/1ps
module tb_vending_controller_param;
    localparam int NP = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          coin_5 = 1'b0, coin_10 = 1'b0, cancel = 1'b0;
    logic [NP-1:0] select = '0;
    logic          dispense, change, coin_reject, busy;
    logic [1:0]    dispense_id;
    logic [CW-1:0] change_amt, credit;
    logic [NP-1:0] sold_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vending_controller_param #(
        .NUM_PRODUCTS(NP), .CREDIT_W(CW), .PRICE_LIST({8'd20, 8'd15, 8'd10}),
        .MAX_CREDIT(50), .DISP_CYCLES(4), .STOCK_INIT(1)
    ) dut (
        .clk(clk), .reset(reset), .coin_5(coin_5), .coin_10(coin_10), .select(select),
        .cancel(cancel), .dispense(dispense), .dispense_id(dispense_id), .change(change),
        .change_amt(change_amt), .credit(credit), .coin_reject(coin_reject), .busy(busy),
        .sold_out(sold_out)
    );

    typedef struct packed {
        logic [CW-1:0] credit;
        logic          disp;
        logic [1:0]    id;
        logic          chg;
        logic [CW-1:0] amt;
        logic          rej;
        logic          busy;
    } exp_t;

    typedef struct {
        logic          c5, c10, can;
        logic [NP-1:0] sel;
        exp_t          e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int c5, int c10, int sel, int can, int cr, int d,
                                int id, int chg, int amt, int rej, int b);
        vec_t v;
        v.c5 = c5[0]; v.c10 = c10[0]; v.can = can[0]; v.sel = NP'(sel);
        v.e.credit = CW'(cr); v.e.disp = d[0]; v.e.id = 2'(id); v.e.chg = chg[0];
        v.e.amt = CW'(amt); v.e.rej = rej[0]; v.e.busy = b[0];
        return v;
    endfunction

    task automatic add(int c5, int c10, int sel, int can, int cr, int d = 0,
                       int id = 0, int chg = 0, int amt = 0, int rej = 0, int b = 0);
        tbl.push_back(mk(c5, c10, sel, can, cr, d, id, chg, amt, rej, b));
    endtask

    task automatic cmp(input string nm, input int idx, input exp_t e);
        logic ok;
        n_vec++;
        ok = (credit == e.credit) && (dispense == e.disp) && (change == e.chg) &&
             (change_amt == e.amt) && (coin_reject == e.rej) && (busy == e.busy) &&
             (!e.disp || dispense_id == e.id);
        if (!ok) begin
            n_err++;
            $display("FAIL %s[%0d]: got cr=%0d disp=%0b id=%0d chg=%0b amt=%0d rej=%0b busy=%0b, want cr=%0d disp=%0b id=%0d chg=%0b amt=%0d rej=%0b busy=%0b",
                     nm, idx, credit, dispense, dispense_id, change, change_amt, coin_reject, busy,
                     e.credit, e.disp, e.id, e.chg, e.amt, e.rej, e.busy);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic c5, input logic c10, input logic [NP-1:0] sel, input logic can);
        @(negedge clk);
        coin_5 = c5; coin_10 = c10; select = sel; cancel = can;
    endtask

    // Each vector's result appears two samples after it is driven; the queue holds that distance.
    task automatic run_table(input string nm);
        exp_t q[$];
        coin_5 = 0; coin_10 = 0; select = '0; cancel = 0;
        do_reset();
        foreach (tbl[k]) begin
            @(negedge clk);
            if (q.size() == 2) cmp(nm, k - 2, q.pop_front());
            coin_5 = tbl[k].c5; coin_10 = tbl[k].c10; select = tbl[k].sel; cancel = tbl[k].can;
            q.push_back(tbl[k].e);
        end
        for (int j = tbl.size() - 2; q.size() > 0; j++) begin
            @(negedge clk);
            cmp(nm, j, q.pop_front());
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0] so_exp;

        // Reset state, with coin_10 held high through reset.
        coin_10 = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_credit", credit, 0);
        chk("rst_outs", {dispense, change, coin_reject, busy}, 0);
        chk("rst_amt_id", {change_amt, dispense_id}, 0);
        chk("rst_sold_out", sold_out, 0);
        repeat (2) @(negedge clk);
        chk("held_coin_ignored", credit, 0);
        coin_10 = 1'b0;
        @(negedge clk);
        coin_10 = 1'b1;
        repeat (2) @(negedge clk);
        chk("repress_coin", credit, 10);
        coin_10 = 1'b0;

        // Two tens, buy product 0 (10): dispense 4 cycles, then change 10.
        add(0,0,0,0, 0);
        add(0,1,0,0, 10); add(0,0,0,0, 10);
        add(0,1,0,0, 20); add(0,0,0,0, 20);
        add(0,0,1,0, 10, 1,0,0,0,0,1);
        repeat (3) add(0,0,0,0, 10, 1,0,0,0,0,1);
        add(0,0,0,0, 0, 0,0,1,10,0,1);
        add(0,0,0,0, 0);
        run_table("vend_change");
`ifdef VEND_STOCK_EN
        so_exp = 3'b001;
`else
        so_exp = 3'b000;
`endif
        chk("sold_out_after_vend", sold_out, so_exp);

        // 5+10 in one cycle, buy product 1 (15): no change.
        add(0,0,0,0, 0);
        add(1,1,0,0, 15); add(0,0,0,0, 15);
        add(0,0,2,0, 0, 1,1,0,0,0,1);
        repeat (3) add(0,0,0,0, 0, 1,1,0,0,0,1);
        add(0,0,0,0, 0); add(0,0,0,0, 0);
        run_table("exact_price");

        // Credit 45, coin 10 rejected, then cancel refunds 45.
        add(0,0,0,0, 0);
        for (int j = 1; j <= 4; j++) begin add(0,1,0,0, 10*j); add(0,0,0,0, 10*j); end
        add(1,0,0,0, 45); add(0,0,0,0, 45);
        add(0,1,0,0, 45, 0,0,0,0,1,0); add(0,0,0,0, 45);
        add(0,0,0,1, 0, 0,0,1,45,0,1);
        add(0,0,0,0, 0);
        run_table("reject_cancel");

        // Credit 30, products 2 and 0 together: 0 wins; coin during dispense rejected.
        add(0,0,0,0, 0);
        for (int j = 1; j <= 3; j++) begin add(0,1,0,0, 10*j); add(0,0,0,0, 10*j); end
        add(0,0,5,0, 20, 1,0,0,0,0,1);
        add(1,0,0,0, 20, 1,0,0,0,1,1);
        add(0,0,0,0, 20, 1,0,0,0,0,1);
        add(0,0,0,0, 20, 1,0,0,0,0,1);
        add(0,0,0,0, 0, 0,0,1,20,0,1);
        add(0,0,0,0, 0);
        run_table("priority_busy_coin");

        // Credit 5: select ignored; cancel+select together refunds.
        add(0,0,0,0, 0);
        add(1,0,0,0, 5); add(0,0,0,0, 5);
        add(0,0,1,0, 5); add(0,0,0,0, 5);
        add(0,0,1,1, 0, 0,0,1,5,0,1);
        add(0,0,0,0, 0);
        run_table("short_credit_cancel");

        // Boundary: reach exactly 50, then a further 5 is rejected, refund 50.
        add(0,0,0,0, 0);
        for (int j = 1; j <= 5; j++) begin add(0,1,0,0, 10*j); add(0,0,0,0, 10*j); end
        add(1,0,0,0, 50, 0,0,0,0,1,0); add(0,0,0,0, 50);
        add(0,0,0,1, 0, 0,0,1,50,0,1);
        add(0,0,0,0, 0);
        run_table("max_credit");

        // Reset during DISPENSE aborts without change.
        do_reset();
        step(0,1,0,0); step(0,0,0,0); step(0,1,0,0); step(0,0,0,0);
        step(0,0,3'b010,0); step(0,0,0,0);
        @(negedge clk);
        chk("pre_rst_dispense", dispense, 1);
        chk("pre_rst_credit", credit, 5);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {dispense, change, coin_reject, busy}, 0);
        chk("rst_mid_credit", credit, 0);
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("post_rst_quiet", {dispense, change, busy, credit}, 0);
        end

        // Stock: second vend of product 0 with one unit in stock.
        do_reset();
        step(0,1,0,0); step(0,0,0,0); step(0,0,3'b001,0); step(0,0,0,0);
        repeat (6) @(negedge clk);
        chk("stock_sold_out", sold_out, so_exp);
        step(0,1,0,0); step(0,0,0,0); step(0,0,3'b001,0); step(0,0,0,0);
        @(negedge clk);
`ifdef VEND_STOCK_EN
        chk("stock_second_disp", dispense, 0);
        chk("stock_credit_kept", credit, 10);
`else
        chk("stock_second_disp", dispense, 1);
        chk("stock_credit_kept", credit, 0);
`endif
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vending_controller_param.md
# vending_controller_param

Parametrised next-generation vending controller that replaces the fixed two-coin/three-product FSM behind the board-level wrapper. Supports N products with per-product prices, a saturating credit register, cancel/refund, a multi-cycle dispense pulse with product index, and a change amount output. The block sits directly under the board top, with switches on its inputs and LEDs or a display driver on its outputs.

## Interface
- NUM_PRODUCTS, 3, number of selectable products (1..8)
- CREDIT_W, 8, width of credit, price and change values
- PRICE_LIST, {8'd20,8'd15,8'd10}, packed NUM_PRODUCTS*CREDIT_W prices; product i occupies bits [i*CREDIT_W +: CREDIT_W]
- MAX_CREDIT, 50, maximum credit accepted (must be < 2**CREDIT_W)
- DISP_CYCLES, 4, cycles that dispense stays high (>=1)
- STOCK_INIT, 5, initial stock per product (used only with VEND_STOCK_EN)

- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- coin_5  in  1  level input; rising edge = ₹5 inserted
- coin_10  in  1  level input; rising edge = ₹10 inserted
- select  in  NUM_PRODUCTS  level inputs; rising edge of bit i = product i requested
- cancel  in  1  level input; rising edge = refund request
- dispense  out  1  high for DISP_CYCLES cycles per vend
- dispense_id  out  clog2(NUM_PRODUCTS) (min 1)  product index, valid while dispense is high
- change  out  1  single-cycle pulse when change or refund is returned
- change_amt  out  CREDIT_W  amount returned, valid while change is high, otherwise 0
- credit  out  CREDIT_W  current accumulated credit
- coin_reject  out  1  single-cycle pulse when a coin edge is not accepted
- busy  out  1  high in DISPENSE and CHANGE
- sold_out  out  NUM_PRODUCTS  per-product empty flags

## Operation
- All inputs are synchronous to clk. The block edge-detects each input with a registered previous value. Previous-value registers reset to 1, so a switch held high through reset is ignored until it is released and pressed again.
- States: IDLE (credit 0), CREDIT (credit > 0), DISPENSE, CHANGE.
- Coin value per cycle = 5·edge(coin_5) + 10·edge(coin_10). Two simultaneous edges add 15.
- In IDLE/CREDIT, a coin is accepted when credit + value <= MAX_CREDIT. Otherwise the whole coin value is rejected: coin_reject pulses and credit is unchanged.
- In DISPENSE/CHANGE, every coin edge is rejected.
- Select in IDLE/CREDIT:
  - If several select edges arrive in the same cycle, the lowest index wins and the others are ignored.
  - The winner is accepted if registered credit >= price[i] and the product is not sold out.
  - On acceptance: credit becomes credit − price[i] plus any coin accepted in the same cycle, dispense_id is latched, and the state goes to DISPENSE.
  - A select with insufficient credit or a sold-out product is ignored, with no state change.
- Cancel in CREDIT → CHANGE. Cancel in IDLE has no effect. If cancel and select arrive in the same cycle, cancel wins. A coin accepted in the same cycle as cancel is included in the refund.
- DISPENSE: dispense stays high for exactly DISP_CYCLES cycles. Afterwards the state goes to CHANGE if credit > 0, else to IDLE.
- CHANGE: lasts one cycle. change = 1 and change_amt = credit; credit is cleared; the next state is IDLE.
- Select and cancel edges in DISPENSE/CHANGE are discarded, not queued.
- Credit arithmetic uses CREDIT_W+1 bits internally. Credit never exceeds MAX_CREDIT and never goes negative.

## Timing
- Reset values: dispense = 0, dispense_id = 0, change = 0, change_amt = 0, credit = 0, coin_reject = 0, busy = 0, state = IDLE. sold_out = 0 with the macro enabled (stock reloads to STOCK_INIT) and 0 without it.
- Reset asserted mid-DISPENSE or mid-CHANGE aborts immediately. Credit is lost and no change is issued.
- An input edge sampled at clock edge n produces updated credit, coin_reject, dispense, or change visible after edge n+1 (one-cycle latency).
- Dispense is high on cycles n+1 .. n+DISP_CYCLES. Change follows on cycle n+DISP_CYCLES+1.
- busy equals (state == DISPENSE || state == CHANGE), registered.

## Configuration
- VEND_STOCK_EN defined:
  - Per-product stock counters, width clog2(STOCK_INIT+1), reset to STOCK_INIT.
  - A counter decrements on entry to DISPENSE for its product.
  - sold_out[i] = (stock[i] == 0).
  - A select of a sold-out product is ignored and credit is kept.
- VEND_STOCK_EN undefined: no counters, sold_out tied to 0, unlimited vends.

## Test plan
- Defaults: coin_10, coin_10 edges then select[0] edge → credit 10 then 20; dispense high 4 cycles with dispense_id = 0; change pulse with change_amt = 10; credit = 0; IDLE.
- coin_5 and coin_10 edges in the same cycle, then select[1] → credit 15; dispense with id = 1; no change pulse.
- Credit 45, coin_10 edge → coin_reject pulse, credit stays 45. Then cancel → change_amt = 45, credit 0.
- Credit 30, select[2] and select[0] edges in the same cycle → id 0 dispensed, change_amt = 20. A coin_5 edge during DISPENSE → coin_reject, change_amt still 20.
- Credit 5, select[0] → ignored. Cancel and select in the same cycle → refund 5, no dispense. Reset asserted during DISPENSE → all outputs 0 next cycle.
- VEND_STOCK_EN with STOCK_INIT = 1: two vends of product 0 → second select ignored, sold_out[0] = 1, credit retained.
